// File: rtl/regfile_wb_queue_if.sv
// rtl/regfile_wb_queue_if.sv - producer, regfile write and bypass signals of the writeback queue
interface regfile_wb_queue_if #(
    parameter int DATA_W = 32,
    parameter int NUM_W  = 5
);
    logic              alu_valid;
    logic [NUM_W-1:0]  alu_num;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [NUM_W-1:0]  mem_num;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic [NUM_W-1:0]  write_num;
    logic [DATA_W-1:0] write_data;
    logic              write_en;
    logic [NUM_W-1:0]  lookup_num;
    logic              lookup_hit;
    logic [DATA_W-1:0] lookup_data;

    modport slave (
        input  alu_valid, alu_num, alu_data, mem_valid, mem_num, mem_data, lookup_num,
        output alu_ready, mem_ready, write_num, write_data, write_en, lookup_hit, lookup_data
    );

    modport master (
        output alu_valid, alu_num, alu_data, mem_valid, mem_num, mem_data, lookup_num,
        input  alu_ready, mem_ready, write_num, write_data, write_en, lookup_hit, lookup_data
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - buffers ALU/load results and drains one per cycle into the regfile
module regfile_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int NUM_W  = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wb_stall_i,
    regfile_wb_queue_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [NUM_W-1:0]  num_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wen_q, wen_d;
    logic [NUM_W-1:0]  wnum_q, wnum_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              not_full, enq_fire, push, pop;
    logic [NUM_W-1:0]  enq_num;
    logic [DATA_W-1:0] enq_data;

    // Full stalls both producers even if the head pops this cycle; MEM wins ties.
    assign not_full      = (count_q < CNT_W'(DEPTH));
    assign bus.mem_ready = not_full;
    assign bus.alu_ready = not_full && !bus.mem_valid;

    assign enq_fire = not_full && (bus.mem_valid || bus.alu_valid);
    assign enq_num  = bus.mem_valid ? bus.mem_num  : bus.alu_num;
    assign enq_data = bus.mem_valid ? bus.mem_data : bus.alu_data;
    // r0 writes are acknowledged but never stored.
    assign push     = enq_fire && (enq_num != '0);
    assign pop      = (count_q != '0) && !wb_stall_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wen_d   = 1'b0;
        wnum_d  = wnum_q;
        wdata_d = wdata_q;
        if (pop) begin
            wen_d   = 1'b1;
            wnum_d  = num_mem[head_q];
            wdata_d = data_mem[head_q];
            head_d  = head_q + PTR_W'(1);
        end
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wen_q   <= 1'b0;
            wnum_q  <= '0;
            wdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wen_q   <= wen_d;
            wnum_q  <= wnum_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            num_mem[tail_q]  <= enq_num;
            data_mem[tail_q] <= enq_data;
        end
    end

    // Later matches overwrite earlier ones, so the newest pending value wins.
    logic [PTR_W-1:0]  idx;
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    always_comb begin
        idx      = '0;
        hit      = 1'b0;
        hit_data = '0;
        if (wen_q && (wnum_q == bus.lookup_num)) begin
            hit      = 1'b1;
            hit_data = wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (num_mem[idx] == bus.lookup_num)) begin
                hit      = 1'b1;
                hit_data = data_mem[idx];
            end
        end
        if (bus.lookup_num == '0) begin
            hit      = 1'b0;
            hit_data = '0;
        end
    end

    assign bus.lookup_hit  = hit;
    assign bus.lookup_data = hit_data;
    assign bus.write_en    = wen_q;
    assign bus.write_num   = wnum_q;
    assign bus.write_data  = wdata_q;
    assign count_o         = count_q;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - vector table, directed corner sequences and random model checks
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wb_stall = 1'b0;
    logic [2:0] count;

    regfile_wb_queue_if #(.DATA_W(32), .NUM_W(5)) bus ();

    regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(32), .NUM_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_stall_i(wb_stall),
        .bus       (bus),
        .count_o   (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  num;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    bit          m_wen = 0;
    logic [4:0]  m_wnum = '0;
    logic [31:0] m_wdata = '0;

    typedef struct {
        logic        mv; logic [4:0] mn; logic [31:0] md;
        logic        av; logic [4:0] an; logic [31:0] ad;
        logic        st; logic [4:0] ln;
        logic        e_mr, e_ar; logic [2:0] e_cnt;
        logic        e_we; logic [4:0] e_wn; logic [31:0] e_wd;
        logic        e_hit; logic [31:0] e_ld;
    } vec_t;

    vec_t vec[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic mv, input logic [4:0] mn, input logic [31:0] md,
                         input logic av, input logic [4:0] an, input logic [31:0] ad,
                         input logic st, input logic [4:0] ln);
        bus.mem_valid = mv; bus.mem_num = mn; bus.mem_data = md;
        bus.alu_valid = av; bus.alu_num = an; bus.alu_data = ad;
        wb_stall = st; bus.lookup_num = ln;
    endtask

    function automatic void model_lookup(input logic [4:0] n, output logic h, output logic [31:0] d);
        h = 1'b0; d = '0;
        if (n == 0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].num == n) begin
                h = 1'b1; d = mq[i].data; return;
            end
        end
        if (m_wen && m_wnum == n) begin
            h = 1'b1; d = m_wdata;
        end
    endfunction

    task automatic model_compare();
        logic        h;
        logic [31:0] d;
        bit          room;
        room = (mq.size() < DEPTH);
        model_lookup(bus.lookup_num, h, d);
        chk("mem_ready",   bus.mem_ready, room);
        chk("alu_ready",   bus.alu_ready, room && !bus.mem_valid);
        chk("count",       count, mq.size());
        chk("write_en",    bus.write_en, m_wen);
        chk("write_num",   bus.write_num, m_wnum);
        chk("write_data",  bus.write_data, m_wdata);
        chk("lookup_hit",  bus.lookup_hit, h);
        chk("lookup_data", bus.lookup_data, d);
    endtask

    task automatic model_update();
        bit          room, take;
        ent_t        e;
        room = (mq.size() < DEPTH);
        take = room && (bus.mem_valid || bus.alu_valid);
        e.num  = bus.mem_valid ? bus.mem_num  : bus.alu_num;
        e.data = bus.mem_valid ? bus.mem_data : bus.alu_data;
        if (mq.size() > 0 && !wb_stall) begin
            m_wen = 1; m_wnum = mq[0].num; m_wdata = mq[0].data;
            void'(mq.pop_front());
        end else begin
            m_wen = 0;
        end
        if (take && e.num != 0) mq.push_back(e);
    endtask

    task automatic step(input int row);
        #1;
        if (row >= 0) begin
            chk($sformatf("v%0d_mem_ready", row), bus.mem_ready, vec[row].e_mr);
            chk($sformatf("v%0d_alu_ready", row), bus.alu_ready, vec[row].e_ar);
            chk($sformatf("v%0d_count", row), count, vec[row].e_cnt);
            chk($sformatf("v%0d_write_en", row), bus.write_en, vec[row].e_we);
            chk($sformatf("v%0d_write_num", row), bus.write_num, vec[row].e_wn);
            chk($sformatf("v%0d_write_data", row), bus.write_data, vec[row].e_wd);
            chk($sformatf("v%0d_lookup_hit", row), bus.lookup_hit, vec[row].e_hit);
            chk($sformatf("v%0d_lookup_data", row), bus.lookup_data, vec[row].e_ld);
        end
        model_compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        //          mv mn md     av an ad           st ln   mr ar cnt we wn wd           hit ld
        vec[0] = '{0, 0, 0,     0, 0, 0,           0, 0,   1, 1, 0, 0, 0, 0,           0, 0};
        vec[1] = '{0, 0, 0,     1, 3, 32'hDEADBEEF, 0, 3,  1, 1, 0, 0, 0, 0,           0, 0};
        vec[2] = '{0, 0, 0,     0, 0, 0,           0, 3,   1, 1, 1, 0, 0, 0,           1, 32'hDEADBEEF};
        vec[3] = '{0, 0, 0,     0, 0, 0,           0, 3,   1, 1, 0, 1, 3, 32'hDEADBEEF, 1, 32'hDEADBEEF};
        vec[4] = '{1, 4, 32'h11, 1, 5, 32'h22,     0, 4,   1, 0, 0, 0, 3, 32'hDEADBEEF, 0, 0};
        vec[5] = '{0, 0, 0,     1, 5, 32'h22,      0, 4,   1, 1, 1, 0, 3, 32'hDEADBEEF, 1, 32'h11};
        vec[6] = '{0, 0, 0,     0, 0, 0,           0, 5,   1, 1, 1, 1, 4, 32'h11,      1, 32'h22};
        vec[7] = '{0, 0, 0,     1, 0, 32'hFFFF,    0, 0,   1, 1, 0, 1, 5, 32'h22,      0, 0};
        vec[8] = '{0, 0, 0,     0, 0, 0,           0, 0,   1, 1, 0, 0, 5, 32'h22,      0, 0};
        vec[9] = '{0, 0, 0,     0, 0, 0,           0, 5,   1, 1, 0, 0, 5, 32'h22,      0, 0};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 10; r++) begin
            drive(vec[r].mv, vec[r].mn, vec[r].md, vec[r].av, vec[r].an, vec[r].ad,
                  vec[r].st, vec[r].ln);
            step(r);
        end

        // fill under stall, fifth offer held, then ordered drain
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, 1, 5'(k), 32'(100 + k), 1, 0);
            step(-1);
        end
        drive(0, 0, 0, 1, 5'd5, 32'd105, 1, 0);
        #1;
        chk("fill_count", count, 4);
        chk("fill_alu_ready", bus.alu_ready, 0);
        chk("fill_mem_ready", bus.mem_ready, 0);
        step(-1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step(-1);
            chk("drain_we", bus.write_en, 1);
            chk("drain_num", bus.write_num, k);
            chk("drain_data", bus.write_data, 100 + k);
        end
        step(-1);
        chk("drain_done_we", bus.write_en, 0);

        // bypass returns newest of two writes to the same register
        drive(0, 0, 0, 1, 5'd7, 32'h1, 1, 7); step(-1);
        drive(0, 0, 0, 1, 5'd7, 32'h2, 1, 7); step(-1);
        drive(0, 0, 0, 0, 0, 0, 1, 7);
        #1;
        chk("byp_hit", bus.lookup_hit, 1);
        chk("byp_data", bus.lookup_data, 2);
        step(-1);
        drive(0, 0, 0, 0, 0, 0, 0, 7);
        step(-1);
        #1;
        chk("byp_mid_data", bus.lookup_data, 2);
        step(-1);
        #1;
        chk("byp_wstage_data", bus.lookup_data, 2);
        step(-1);
        step(-1);

        // reset while draining
        for (int k = 1; k <= 3; k++) begin
            drive(0, 0, 0, 1, 5'(8 + k), 32'(200 + k), 1, 0);
            step(-1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(-1);
        chk("pre_rst_we", bus.write_en, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_we", bus.write_en, 0);
        chk("rst_count", count, 0);
        chk("rst_num", bus.write_num, 0);
        mq.delete(); m_wen = 0; m_wnum = '0; m_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(-1);

        // random traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1) == 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)));
            step(-1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
